// File: rtl/lcd_timing_driver.sv
// rtl/lcd_timing_driver.sv - RGB LCD raster timing generator with power-up sequencing
// Pixel coordinates lead DE by one pclk so the generator's registered data lands on DE.
module lcd_timing_driver #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int PWR_DLY = 1000
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_done
);

  localparam logic [10:0] H_MAX  = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [10:0] V_MAX  = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [10:0] HS_END = 11'(H_SYNC);
  localparam logic [10:0] VS_END = 11'(V_SYNC);
  localparam logic [10:0] HA     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HA_END = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] REQ_LO = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] REQ_HI = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] X_OFS  = 11'(H_SYNC + H_BACK - 2);
  localparam logic [10:0] VA     = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VA_END = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] Y_OFS  = 11'(V_SYNC + V_BACK - 1);

  localparam int              DW       = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam logic [DW-1:0]   DLY_LAST = DW'(PWR_DLY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [10:0]   h_cnt, h_nx;
  logic [10:0]   v_cnt, v_nx;
  logic [DW-1:0] dly_cnt, dly_nx;

  logic timing;
  logic run;
  logic v_act;
  logic req_win;

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      dly_cnt <= '0;
    end else begin
      state   <= state_nx;
      h_cnt   <= h_nx;
      v_cnt   <= v_nx;
      dly_cnt <= dly_nx;
    end
  end

  always_comb begin
    state_nx = state;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    dly_nx   = dly_cnt;
    case (state)
      IDLE: begin
        h_nx = '0;
        v_nx = '0;
        if (dly_cnt == DLY_LAST) begin
          state_nx = BLANK;
          dly_nx   = '0;
        end else begin
          dly_nx = dly_cnt + DW'(1);
        end
      end
      BLANK, RUN: begin
        if (h_cnt == H_MAX) begin
          h_nx = '0;
          v_nx = (v_cnt == V_MAX) ? 11'd0 : v_cnt + 11'd1;
        end else begin
          h_nx = h_cnt + 11'd1;
        end
        // The single blank frame ends on its own frame_done cycle.
        if (state == BLANK && frame_done) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign timing  = (state == BLANK) || (state == RUN);
  assign run     = (state == RUN);
  assign v_act   = run && (v_cnt >= VA) && (v_cnt < VA_END);
  assign req_win = v_act && (h_cnt >= REQ_LO) && (h_cnt < REQ_HI);

  assign lcd_hs     = !(timing && (h_cnt < HS_END));
  assign lcd_vs     = !(timing && (v_cnt < VS_END));
  assign lcd_de     = v_act && (h_cnt >= HA) && (h_cnt < HA_END);
  assign lcd_bl     = run;
  assign frame_done = timing && (h_cnt == H_MAX) && (v_cnt == V_MAX);

  assign pixel_xpos = req_win ? (h_cnt - X_OFS) : 11'd0;
  assign pixel_ypos = v_act ? (v_cnt - Y_OFS) : 11'd0;
  assign lcd_rgb    = lcd_de ? pixel_data : 24'd0;

  assign h_disp = 11'(H_DISP);
  assign v_disp = 11'(V_DISP);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb/tb_lcd_timing_driver.sv - scoreboard bench for lcd_timing_driver on a 16x8 raster
module tb_lcd_timing_driver;

  localparam int HS = 4, HB = 2, HD = 8, HF = 2;
  localparam int VS = 2, VB = 1, VD = 4, VF = 1;
  localparam int PD = 5;

  logic        lcd_pclk = 1'b0;
  logic        rst_n    = 1'b0;
  logic [23:0] pixel_data = '0;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_done;
  logic [23:0] lcd_rgb;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;

  lcd_timing_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .PWR_DLY(PD)
  ) dut (
    .lcd_pclk  (lcd_pclk),
    .rst_n     (rst_n),
    .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .h_disp    (h_disp),
    .v_disp    (v_disp),
    .lcd_hs    (lcd_hs),
    .lcd_vs    (lcd_vs),
    .lcd_de    (lcd_de),
    .lcd_rgb   (lcd_rgb),
    .lcd_bl    (lcd_bl),
    .frame_done(frame_done)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // Pixel generator: one-cycle registered lookup of the requested coordinate.
  always @(posedge lcd_pclk)
    pixel_data <= {pixel_xpos[7:0], 8'h00, pixel_ypos[7:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge lcd_pclk) begin
    if (lcd_de === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("de_without_expectation", 32'(lcd_de), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rgb", 32'(lcd_rgb), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge lcd_pclk);
    @(negedge lcd_pclk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hs"},    32'(lcd_hs),     32'd1);
    check({tag, "_vs"},    32'(lcd_vs),     32'd1);
    check({tag, "_de"},    32'(lcd_de),     32'd0);
    check({tag, "_bl"},    32'(lcd_bl),     32'd0);
    check({tag, "_rgb"},   32'(lcd_rgb),    32'd0);
    check({tag, "_xpos"},  32'(pixel_xpos), 32'd0);
    check({tag, "_ypos"},  32'(pixel_ypos), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  task automatic push_rows(input int rows, input int cols);
    for (int r = 1; r <= rows; r++)
      for (int c = 1; c <= cols; c++)
        exp_q.push_back({8'(c), 8'h00, 8'(r)});
  endtask

  // Samples one 128-cycle frame starting at the current sample (h=0, v=0).
  task automatic run_frame(input bit is_run, input string tag);
    int   de_n = 0, hs_pulse = 0, vs_low = 0, fd_n = 0, bad = 0, hs_low_l0 = 0;
    logic prev_hs = 1'b1;
    for (int o = 0; o < 128; o++) begin
      if (o > 0) tick();
      if (lcd_de) de_n++;
      if (!lcd_hs && prev_hs) hs_pulse++;
      prev_hs = lcd_hs;
      if (!lcd_vs) vs_low++;
      if (frame_done) fd_n++;
      if (o < 16 && !lcd_hs) hs_low_l0++;
      if (o == 127) check({tag, "_fdone_last_cycle"}, 32'(frame_done), 32'd1);
      if (!is_run && (lcd_de || lcd_rgb != 0 || pixel_xpos != 0 || pixel_ypos != 0)) bad++;
      if (is_run && o == 0) check({tag, "_bl_on"}, 32'(lcd_bl), 32'd1);
      if (is_run && o >= 48 && o < 64) begin
        int h = o - 48;
        int ex = (h >= 5 && h <= 12) ? h - 4 : 0;
        int ed = (h >= 6 && h <= 13) ? 1 : 0;
        check({tag, "_line3_xpos"}, 32'(pixel_xpos), 32'(ex));
        check({tag, "_line3_de"},   32'(lcd_de),     32'(ed));
        check({tag, "_line3_ypos"}, 32'(pixel_ypos), 32'd1);
      end
    end
    check({tag, "_de_cycles"},  32'(de_n),      is_run ? 32'd32 : 32'd0);
    check({tag, "_hs_pulses"},  32'(hs_pulse),  32'd8);
    check({tag, "_vs_low"},     32'(vs_low),    32'd32);
    check({tag, "_fdone_cnt"},  32'(fd_n),      32'd1);
    check({tag, "_hs_width"},   32'(hs_low_l0), 32'd4);
    if (!is_run) check({tag, "_blank_quiet"}, 32'(bad), 32'd0);
  endtask

  // Entered on the sample just after reset release; returns at RUN frame start.
  task automatic startup(input string tag);
    for (int c = 0; c < PD; c++) begin
      if (c > 0) tick();
      check({tag, "_idle_outputs"}, 32'({lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_done}), 32'b11000);
    end
    tick();
    check({tag, "_first_hs_low"}, 32'(lcd_hs), 32'd0);
    run_frame(1'b0, {tag, "_blank"});
    check({tag, "_bl_before"}, 32'(lcd_bl), 32'd0);
    tick();
    check({tag, "_bl_after"}, 32'(lcd_bl), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset("por");
    check("h_disp", 32'(h_disp), 32'd8);
    check("v_disp", 32'(v_disp), 32'd4);

    rst_n = 1'b1;
    startup("s1");
    for (int f = 0; f < 3; f++) begin
      push_rows(VD, HD);
      run_frame(1'b1, "run");
      tick();
    end

    // Reset mid-way through the first active line, after columns 1..3.
    push_rows(1, 3);
    repeat (56) tick();
    check("mid_line_de", 32'(lcd_de), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset("mid");
    rst_n = 1'b1;
    startup("s2");
    push_rows(VD, HD);
    run_frame(1'b1, "run2");
    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
